// File: rtl/sub1_src.sv
// Byte-to-frame source: gathers three bytes, strobes them downstream as a frame,
// then waits (bounded by TIMEOUT cycles) for a response and captures it.
module sub1_src #(
    parameter int TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_byte_valid,
    output logic            o_byte_ready,
    input  logic [7:0]      i_byte_data,
    output logic            o_sig_a,
    output logic [1:0]      o_sig_b,
    output logic [0:2][7:0] o_sig_c,
    output logic [7:0]      o_sig_d [3],
    input  logic            i_sig_e,
    input  logic [1:0]      i_sig_f,
    input  logic [0:2][7:0] i_sig_g,
    input  logic [7:0]      i_sig_h [3],
    output logic            o_rsp_valid,
    output logic [1:0]      o_rsp_status,
    output logic [0:2][7:0] o_rsp_data,
    output logic            o_rsp_match,
    output logic            o_timeout
);

    localparam logic [1:0]  COLLECT = 2'd0;
    localparam logic [1:0]  SEND    = 2'd1;
    localparam logic [1:0]  WAIT    = 2'd2;
    localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    // Slots 0 and 1 only; slot 2 is the byte in flight on the final handshake.
    logic [7:0]       buf_q [2];
    logic [7:0]       buf_d [2];
    logic [1:0]       seq_q, seq_d;
    logic [15:0]      wcnt_q, wcnt_d;
    logic [0:2][7:0]  sig_c_q, sig_c_d;
    logic [7:0]       sig_d_q [3];
    logic [7:0]       sig_d_d [3];
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_status_q, rsp_status_d;
    logic [0:2][7:0]  rsp_data_q, rsp_data_d;
    logic             rsp_match_q, rsp_match_d;
    logic             timeout_q, timeout_d;
    logic             accept;
    logic             match;

    assign accept = i_byte_valid && (state_q == COLLECT);
    assign match  = (i_sig_g[0] == i_sig_h[0]) && (i_sig_g[1] == i_sig_h[1]) &&
                    (i_sig_g[2] == i_sig_h[2]);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        seq_d        = seq_q;
        wcnt_d       = wcnt_q;
        sig_c_d      = sig_c_q;
        sig_d_d      = sig_d_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        rsp_match_d  = rsp_match_q;
        timeout_d    = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (cnt_q == 2'd2) begin
                        sig_c_d    = {buf_q[0], buf_q[1], i_byte_data};
                        sig_d_d[0] = buf_q[0];
                        sig_d_d[1] = buf_q[1];
                        sig_d_d[2] = i_byte_data;
                        cnt_d      = 2'd0;
                        state_d    = SEND;
                    end else begin
                        buf_d[cnt_q[0]] = i_byte_data;
                        cnt_d           = cnt_q + 2'd1;
                    end
                end
            end
            SEND: begin
                wcnt_d  = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                // A response in the last allowed cycle wins over the timeout.
                if (i_sig_e) begin
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = i_sig_f;
                    rsp_data_d   = i_sig_g;
                    rsp_match_d  = match;
                    seq_d        = seq_q + 2'd1;
                    state_d      = COLLECT;
                end else if (wcnt_q == WCNT_LAST) begin
                    timeout_d = 1'b1;
                    seq_d     = seq_q + 2'd1;
                    state_d   = COLLECT;
                end else begin
                    wcnt_d = wcnt_q + 16'd1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= COLLECT;
            cnt_q        <= 2'd0;
            buf_q[0]     <= 8'd0;
            buf_q[1]     <= 8'd0;
            seq_q        <= 2'd0;
            wcnt_q       <= 16'd0;
            sig_c_q      <= '0;
            sig_d_q[0]   <= 8'd0;
            sig_d_q[1]   <= 8'd0;
            sig_d_q[2]   <= 8'd0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= 2'd0;
            rsp_data_q   <= '0;
            rsp_match_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            seq_q        <= seq_d;
            wcnt_q       <= wcnt_d;
            sig_c_q      <= sig_c_d;
            sig_d_q      <= sig_d_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
            rsp_match_q  <= rsp_match_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_byte_ready = (state_q == COLLECT);
    assign o_sig_a      = (state_q == SEND);
    assign o_sig_b      = seq_q;
    assign o_sig_c      = sig_c_q;
    assign o_sig_d      = sig_d_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_status = rsp_status_q;
    assign o_rsp_data   = rsp_data_q;
    assign o_rsp_match  = rsp_match_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_sub1_src.sv
// Scoreboard bench for sub1_src: stimulus pushes expected frames/responses,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_sub1_src;

    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            bvalid = 1'b0;
    logic            bready;
    logic [7:0]      bdata = 8'd0;
    logic            sig_a;
    logic [1:0]      sig_b;
    logic [0:2][7:0] sig_c;
    logic [7:0]      sig_d [3];
    logic            sig_e = 1'b0;
    logic [1:0]      sig_f = 2'd0;
    logic [0:2][7:0] sig_g = '0;
    logic [7:0]      sig_h [3];
    logic            rsp_valid;
    logic [1:0]      rsp_status;
    logic [0:2][7:0] rsp_data;
    logic            rsp_match;
    logic            tmo;

    sub1_src #(.TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_byte_valid(bvalid), .o_byte_ready(bready),
        .i_byte_data(bdata), .o_sig_a(sig_a), .o_sig_b(sig_b), .o_sig_c(sig_c),
        .o_sig_d(sig_d), .i_sig_e(sig_e), .i_sig_f(sig_f), .i_sig_g(sig_g),
        .i_sig_h(sig_h), .o_rsp_valid(rsp_valid), .o_rsp_status(rsp_status),
        .o_rsp_data(rsp_data), .o_rsp_match(rsp_match), .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  seq;
        logic [23:0] bytes;
    } frame_t;

    typedef struct packed {
        logic        is_tmo;
        logic [1:0]  status;
        logic [23:0] data;
        logic        match;
    } rsp_t;

    frame_t frame_q [$];
    rsp_t   rsp_q [$];

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [1:0]  exp_seq = 2'd0;
    logic [1:0]  last_status = 2'd0;
    logic [23:0] last_data = 24'd0;
    logic        last_match = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops an expectation each time the DUT strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (sig_a) begin
                if (frame_q.size() == 0) check("unexpected_frame", 32'd1, 32'd0);
                else begin
                    frame_t f;
                    f = frame_q.pop_front();
                    check("frame_seq", 32'(sig_b), 32'(f.seq));
                    check("frame_sig_c", 32'(sig_c), 32'(f.bytes));
                    check("frame_sig_d", {8'd0, sig_d[0], sig_d[1], sig_d[2]}, 32'(f.bytes));
                end
            end
            if (rsp_valid && tmo) check("valid_and_timeout", 32'd1, 32'd0);
            if (rsp_valid || tmo) begin
                if (rsp_q.size() == 0) check("unexpected_pulse", {30'd0, rsp_valid, tmo}, 32'd0);
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("pulse_kind_timeout", 32'(tmo), 32'(r.is_tmo));
                    check("rsp_status", 32'(rsp_status), 32'(r.status));
                    check("rsp_data", 32'(rsp_data), 32'(r.data));
                    check("rsp_match", 32'(rsp_match), 32'(r.match));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        bvalid = 1'b1;
        bdata  = b;
        while (!bready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("byte_ready_timeout", 32'd0, 32'd1);
        tick();
        bvalid = 1'b0;
    endtask

    // Returns during the SEND cycle.
    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        frame_q.push_back('{seq: exp_seq, bytes: {b0, b1, b2}});
        put_byte(b0);
        put_byte(b1);
        put_byte(b2);
        sig_e = 1'b0;
        check("strobe_latency", 32'(sig_a), 32'd1);
        check("ready_low_in_send", 32'(bready), 32'd0);
    endtask

    // Drive a response on WAIT cycle k (1-based), starting from the SEND cycle.
    task automatic respond(input int k, input logic [1:0] f, input logic [23:0] g, input logic [23:0] h);
        logic m;
        m = (g == h);
        rsp_q.push_back('{is_tmo: 1'b0, status: f, data: g, match: m});
        last_status = f;
        last_data   = g;
        last_match  = m;
        repeat (k) tick();
        sig_e    = 1'b1;
        sig_f    = f;
        sig_g    = g;
        sig_h[0] = h[23:16];
        sig_h[1] = h[15:8];
        sig_h[2] = h[7:0];
        tick();
        sig_e = 1'b0;
        check("rsp_valid_pulse", {30'd0, rsp_valid, tmo}, 32'd2);
        exp_seq = exp_seq + 2'd1;
    endtask

    task automatic expect_timeout();
        rsp_q.push_back('{is_tmo: 1'b1, status: last_status, data: last_data, match: last_match});
        repeat (TO) tick();
        check("no_timeout_early", 32'(tmo), 32'd0);
        tick();
        check("timeout_pulse", {30'd0, rsp_valid, tmo}, 32'd1);
        exp_seq = exp_seq + 2'd1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bready), 32'd1);
        check({tag, "_ctrl"}, {26'd0, sig_a, sig_b, rsp_valid, rsp_status, tmo}, 32'd0);
        check({tag, "_sig_c"}, 32'(sig_c), 32'd0);
        check({tag, "_sig_d"}, {8'd0, sig_d[0], sig_d[1], sig_d[2]}, 32'd0);
        check({tag, "_rsp"}, {7'd0, rsp_data, rsp_match}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        frame_q.delete();
        rsp_q.delete();
        exp_seq = 2'd0;
        last_status = 2'd0;
        last_data   = 24'd0;
        last_match  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        sig_h[0] = 8'd0;
        sig_h[1] = 8'd0;
        sig_h[2] = 8'd0;
        #2;
        do_reset();

        // Response on 3rd WAIT cycle, matching copy.
        send_frame(8'h11, 8'h22, 8'h33);
        respond(3, 2'd2, 24'hAABBCC, 24'hAABBCC);
        // i_sig_e held high during COLLECT must be ignored; mismatching copy.
        sig_e = 1'b1;
        send_frame(8'h01, 8'h02, 8'h03);
        respond(1, 2'd1, 24'hAABBCC, 24'hAABBCD);
        // No response: timeout after exactly TO WAIT cycles, old response kept.
        send_frame(8'hA0, 8'hA1, 8'hA2);
        expect_timeout();
        // Response in the final WAIT cycle wins over timeout.
        send_frame(8'hB0, 8'hB1, 8'hB2);
        respond(TO, 2'd3, 24'h123456, 24'h123456);
        // Sequence wraps 3 -> 0.
        send_frame(8'hC0, 8'hC1, 8'hC2);
        respond(2, 2'd0, 24'h00FF00, 24'h00FF00);
        send_frame(8'hD0, 8'hD1, 8'hD2);
        respond(1, 2'd1, 24'h010203, 24'h010203);

        // Reset after two bytes discards them.
        put_byte(8'hE0);
        put_byte(8'hE1);
        do_reset();
        send_frame(8'h44, 8'h55, 8'h66);
        respond(2, 2'd2, 24'h445566, 24'h445566);

        // Reset mid-WAIT: no pulses, sequence restarts.
        send_frame(8'h77, 8'h88, 8'h99);
        tick();
        tick();
        do_reset();
        repeat (TO + 3) tick();
        send_frame(8'h5A, 8'h5B, 8'h5C);
        respond(1, 2'd1, 24'h5A5B5C, 24'h5A5B5C);
        tick();

        check("frames_left", frame_q.size(), 32'd0);
        check("rsps_left", rsp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sub1_src.md
SUB1_SRC -- requirements
Module: sub1_src

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of WAIT cycles allowed for a response (legal range 1..65535).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, the reset, asynchronous and active-high.
REQ-004 SHALL have port i_byte_valid, input, 1, upstream byte valid.
REQ-005 SHALL have port o_byte_ready, output, 1, upstream byte ready.
REQ-006 SHALL have port i_byte_data, input, [7:0], upstream byte.
REQ-007 SHALL have port o_sig_a, output, 1, one-cycle frame strobe to downstream.
REQ-008 SHALL have port o_sig_b, output, [1:0], frame sequence number.
REQ-009 SHALL have port o_sig_c, output, [0:2][7:0], frame as a packed array.
REQ-010 SHALL have port o_sig_d, output, [7:0] unpacked [3], frame as an unpacked array.
REQ-011 SHALL have port i_sig_e, input, 1, response strobe from downstream.
REQ-012 SHALL have port i_sig_f, input, [1:0], response status.
REQ-013 SHALL have port i_sig_g, input, [0:2][7:0], response data, packed.
REQ-014 SHALL have port i_sig_h, input, [7:0] unpacked [3], response data, unpacked copy.
REQ-015 SHALL have port o_rsp_valid, output, 1, one-cycle captured-response strobe.
REQ-016 SHALL have port o_rsp_status, output, [1:0], captured i_sig_f.
REQ-017 SHALL have port o_rsp_data, output, [0:2][7:0], captured i_sig_g.
REQ-018 SHALL have port o_rsp_match, output, 1, set when i_sig_g[k]==i_sig_h[k] for all k=0..2 at capture.
REQ-019 SHALL have port o_timeout, output, 1, one-cycle pulse when no response arrives.

Function
REQ-020 SHALL implement three states: COLLECT, SEND and WAIT.
REQ-021 SHALL drive o_byte_ready=1 only in COLLECT; a byte is accepted on i_byte_valid&&o_byte_ready.
REQ-022 SHALL store the k-th accepted byte (k=0,1,2) of a frame into slot k of an internal frame buffer.
REQ-023 SHALL move from COLLECT to SEND on the cycle after the third byte is accepted.
REQ-024 SHALL, in that cycle, load o_sig_c[k] and o_sig_d[k] with slot k.
REQ-025 SHALL hold o_sig_a=1 for the single SEND cycle and then move to WAIT (latency: third byte accepted at edge N, o_sig_a high after edge N).
REQ-026 SHALL hold o_sig_b, o_sig_c and o_sig_d stable from SEND until the next SEND.
REQ-027 SHALL ignore i_sig_e in COLLECT and SEND.
REQ-028 SHALL, in WAIT on i_sig_e=1, register i_sig_f, i_sig_g and the match flag into o_rsp_status, o_rsp_data and o_rsp_match, pulse o_rsp_valid for one cycle, and return to COLLECT.
REQ-029 SHALL clear the WAIT cycle counter on WAIT entry and increment it on each WAIT cycle without i_sig_e.
REQ-030 SHALL pulse o_timeout and return to COLLECT after exactly TIMEOUT WAIT cycles without i_sig_e; o_rsp_* SHALL then keep their old values.
REQ-031 SHALL treat i_sig_e in the final WAIT cycle as a response: o_rsp_valid=1 and o_timeout=0.
REQ-032 SHALL increment o_sig_b modulo 4 on leaving WAIT, by response or by timeout; 3 wraps to 0.
REQ-033 SHALL never assert o_rsp_valid and o_timeout in the same cycle.

Reset
REQ-034 SHALL, on i_rst=1, immediately set the state to COLLECT, discard any partially collected bytes, and set o_byte_ready=1 and every other output to 0, with o_sig_c and o_sig_d all bytes 0.
REQ-035 SHALL, when reset is asserted mid-WAIT, produce neither o_rsp_valid nor o_timeout, and restart the sequence at 0.

Verification
REQ-036 Bytes 0x11, 0x22, 0x33 back-to-back -> o_sig_a one cycle after the 0x33 handshake; o_sig_c={11,22,33}; o_sig_d[0..2]=11,22,33; o_sig_b=0; o_byte_ready=0.
REQ-037 i_sig_e on the 3rd WAIT cycle with f=2, g=h={AA,BB,CC} -> o_rsp_valid one cycle, o_rsp_status=2, o_rsp_data={AA,BB,CC}, o_rsp_match=1; next frame o_sig_b=1.
REQ-038 g={AA,BB,CC}, h={AA,BB,CD} -> o_rsp_match=0.
REQ-039 TIMEOUT=4, no i_sig_e -> o_timeout after exactly 4 WAIT cycles and o_rsp_valid stays 0; i_sig_e on the 4th WAIT cycle -> o_rsp_valid=1, o_timeout=0.
REQ-040 Five frames, each acknowledged -> o_sig_b sequence 0,1,2,3,0.
REQ-041 i_rst after 2 bytes, then bytes 0x44, 0x55, 0x66 -> frame {44,55,66}, o_sig_b=0; i_rst asserted mid-WAIT -> outputs 0 immediately, no pulses.
